conv_scan_ctrl: RTL and testbench

CONV_SCAN_CTRL -- requirements
Module: conv_scan_ctrl

---
 rtl/conv_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_conv_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/conv_scan_ctrl.sv
// Scan controller for a 5x5 sliding-window convolver: fetches 5-row column bands in
// raster order and tags convolver outputs. Optional abort input: CONV_SCAN_CTRL_ABORT_EN.
`timescale 1ns/1ps
module conv_scan_ctrl #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef CONV_SCAN_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [COORD_W-1:0] rd_row,
    output logic [COORD_W-1:0] rd_col,
    output logic               conv_en,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_row,
    output logic [COORD_W-1:0] out_col
);

    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 5);
    localparam logic [COORD_W-1:0] WIN_SPAN = COORD_W'(4);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t               state_q;
    logic                 drain_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_en_q;
    logic [COORD_W-1:0]   rd_row_q;
    logic [COORD_W-1:0]   rd_col_q;
    logic                 conv_en_q;
    logic [COORD_W-1:0]   tag_row_q;
    logic [COORD_W-1:0]   tag_col_q;
    logic                 out_valid_q;
    logic [COORD_W-1:0]   out_row_q;
    logic [COORD_W-1:0]   out_col_q;
    logic                 abort_hit;
    logic                 win_full;

`ifdef CONV_SCAN_CTRL_ABORT_EN
    assign abort_hit = abort && ((state_q == S_SCAN) || (state_q == S_DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    // The first four columns of each band still hold stale pixels in the window.
    assign win_full = conv_en_q && (tag_col_q >= WIN_SPAN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            conv_en_q   <= 1'b0;
            tag_row_q   <= '0;
            tag_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            conv_en_q   <= rd_en_q && !abort_hit;
            tag_row_q   <= rd_row_q;
            tag_col_q   <= rd_col_q;
            out_valid_q <= win_full && !abort_hit;
            if (win_full) begin
                out_row_q <= tag_row_q;
                out_col_q <= tag_col_q - WIN_SPAN;
            end
            done_q <= 1'b0;
            if (abort_hit) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                rd_en_q <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q  <= S_SCAN;
                            busy_q   <= 1'b1;
                            rd_en_q  <= 1'b1;
                            rd_row_q <= '0;
                            rd_col_q <= '0;
                        end
                    end
                    S_SCAN: begin
                        if (rd_col_q == LAST_COL) begin
                            if (rd_row_q == LAST_ROW) begin
                                state_q <= S_DRAIN;
                                rd_en_q <= 1'b0;
                                drain_q <= 1'b0;
                            end else begin
                                rd_row_q <= rd_row_q + ONE;
                                rd_col_q <= '0;
                            end
                        end else begin
                            rd_col_q <= rd_col_q + ONE;
                        end
                    end
                    // Two cycles let the last fetch travel through conv_en to out_valid.
                    S_DRAIN: begin
                        if (drain_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            drain_q <= 1'b1;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_row    = rd_row_q;
    assign rd_col    = rd_col_q;
    assign conv_en   = conv_en_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Directed bench for conv_scan_ctrl: a 32x32 instance and a 5x5 instance on one clock.
`timescale 1ns/1ps
module tb_conv_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
`ifdef CONV_SCAN_CTRL_ABORT_EN
    logic       abort_a, abort_b;
`endif
    logic       busy_a, done_a, rd_en_a, conv_en_a, out_valid_a;
    logic [7:0] rd_row_a, rd_col_a, out_row_a, out_col_a;
    logic       busy_b, done_b, rd_en_b, conv_en_b, out_valid_b;
    logic [7:0] rd_row_b, rd_col_b, out_row_b, out_col_b;

    int n_assert = 0;
    int n_fail   = 0;

    int         fetch_n, done_n, first_c, order_err, row0_last, row1_first;
    int         idle_busy, restart;
    int         pulse_n [2];
    int         done_c  [2];
    logic       busy_at_done;
    logic [7:0] rd31_row, rd31_col, rd32_row, rd32_col;

    always #5 clk = ~clk;

    conv_scan_ctrl #(.IMG_W(32), .IMG_H(32), .COORD_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
`ifdef CONV_SCAN_CTRL_ABORT_EN
        .abort(abort_a),
`endif
        .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_row(rd_row_a), .rd_col(rd_col_a),
        .conv_en(conv_en_a), .out_valid(out_valid_a), .out_row(out_row_a), .out_col(out_col_a)
    );

    conv_scan_ctrl #(.IMG_W(5), .IMG_H(5), .COORD_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
`ifdef CONV_SCAN_CTRL_ABORT_EN
        .abort(abort_b),
`endif
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_row(rd_row_b), .rd_col(rd_col_b),
        .conv_en(conv_en_b), .out_valid(out_valid_b), .out_row(out_row_b), .out_col(out_col_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle c = 0 is the first negedge after the edge that accepts start on dut_a.
    task automatic run_a(input int max_cyc, input int n_scans, input bit hold, input int stop_at);
        int er, ec;
        er = 0; ec = 0;
        fetch_n = 0; done_n = 0; first_c = -1; order_err = 0;
        row0_last = -1; row1_first = -1; idle_busy = -1; restart = -1;
        pulse_n[0] = 0; pulse_n[1] = 0; done_c[0] = -1; done_c[1] = -1;
        busy_at_done = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            start_a = hold;
            if (rd_en_a) fetch_n++;
            if (done_n == 0 && c == 31) begin rd31_row = rd_row_a; rd31_col = rd_col_a; end
            if (done_n == 0 && c == 32) begin rd32_row = rd_row_a; rd32_col = rd_col_a; end
            if (done_n == 1 && c == done_c[0] + 1) idle_busy = int'(busy_a);
            if (done_n == 1 && c == done_c[0] + 2) restart = int'({busy_a, rd_en_a});
            if (out_valid_a) begin
                if (first_c < 0) first_c = c;
                if (int'(out_row_a) != er || int'(out_col_a) != ec) order_err++;
                if (done_n == 0 && out_row_a == 8'd0 && out_col_a == 8'd27) row0_last = c;
                if (done_n == 0 && out_row_a == 8'd1 && out_col_a == 8'd0) row1_first = c;
                if (done_n < 2) pulse_n[done_n]++;
                ec++;
                if (ec == 28) begin ec = 0; er++; end
            end
            if (done_a) begin
                if (done_n < 2) done_c[done_n] = c;
                busy_at_done = busy_a;
                done_n++;
                er = 0; ec = 0;
            end
            if (c == stop_at || done_n == n_scans) break;
        end
    endtask

    initial begin
        int fb, vb, vcyc, last_rd, dn, dcyc;
        logic [15:0] vcoord;

        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
`ifdef CONV_SCAN_CTRL_ABORT_EN
        abort_a = 1'b0; abort_b = 1'b0;
`endif
        #2;
        chk("reset_a_ctrl", 32'({busy_a, done_a, rd_en_a, conv_en_a, out_valid_a}), 32'd0);
        chk("reset_a_coord", {rd_row_a, rd_col_a, out_row_a, out_col_a}, 32'd0);
        chk("reset_b_ctrl", 32'({busy_b, done_b, rd_en_b, conv_en_b, out_valid_b}), 32'd0);
        @(negedge clk) rst = 1'b1;

        // 5x5 image: one band, one window.
        @(negedge clk) start_b = 1'b1;
        fb = 0; vb = 0; vcyc = -1; last_rd = -1; dn = 0; dcyc = -1; vcoord = 16'hFFFF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (rd_en_b) begin fb++; last_rd = c; end
            if (out_valid_b) begin vb++; vcyc = c; vcoord = {out_row_b, out_col_b}; end
            if (done_b) begin dn++; dcyc = c; end
        end
        chk("b_fetches", fb, 5);
        chk("b_valids", vb, 1);
        chk("b_valid_cycle", vcyc, 6);
        chk("b_valid_coord", 32'(vcoord), 32'd0);
        chk("b_done_count", dn, 1);
        chk("b_done_after_last_rd", dcyc - last_rd, 3);
        chk("b_busy_after", 32'(busy_b), 32'd0);

        // 32x32 single scan.
        @(negedge clk) start_a = 1'b1;
        run_a(1000, 1, 1'b0, -1);
        chk("a_first_valid_cycle", first_c, 6);
        chk("a_pulses", pulse_n[0], 784);
        chk("a_fetches", fetch_n, 896);
        chk("a_done_count", done_n, 1);
        chk("a_done_cycle", done_c[0], 898);
        chk("a_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("a_raster_order", order_err, 0);
        chk("a_rd_c31", {rd31_row, rd31_col}, {16'd0, 8'd0, 8'd31});
        chk("a_rd_c32", {rd32_row, rd32_col}, {16'd0, 8'd1, 8'd0});
        chk("a_band_gap", row1_first - row0_last, 5);
        @(negedge clk);
        chk("a_idle_after", 32'({busy_a, done_a, rd_en_a}), 32'd0);

        // start held high across two scans.
        start_a = 1'b1;
        run_a(2000, 2, 1'b1, -1);
        chk("hold_pulses_1", pulse_n[0], 784);
        chk("hold_pulses_2", pulse_n[1], 784);
        chk("hold_done_1", done_c[0], 898);
        chk("hold_done_2", done_c[1], 1798);
        chk("hold_idle_gap_busy", idle_busy, 0);
        chk("hold_restart", restart, 3);
        chk("hold_raster_order", order_err, 0);
        @(negedge clk) start_a = 1'b0;
        chk("hold_idle_after", 32'(busy_a), 32'd0);

        // Asynchronous reset during row 10.
        @(negedge clk) start_a = 1'b1;
        run_a(1000, 1, 1'b0, 325);
        chk("mid_rd_row", 32'({rd_en_a, rd_row_a}), 32'h10A);
        #1 rst = 1'b0;
        #1;
        chk("mid_reset_ctrl", 32'({busy_a, done_a, rd_en_a, conv_en_a, out_valid_a}), 32'd0);
        chk("mid_reset_coord", {rd_row_a, rd_col_a, out_row_a, out_col_a}, 32'd0);
        @(negedge clk) rst = 1'b1;
        run_a(20, 1, 1'b0, -1);
        chk("post_reset_quiet", 32'(fetch_n + pulse_n[0] + done_n), 32'd0);
        @(negedge clk) start_a = 1'b1;
        run_a(1000, 1, 1'b0, -1);
        chk("rescan_pulses", pulse_n[0], 784);
        chk("rescan_done", done_n, 1);
        chk("rescan_order", order_err, 0);

`ifdef CONV_SCAN_CTRL_ABORT_EN
        @(negedge clk);
        @(negedge clk) start_a = 1'b1;
        run_a(200, 1, 1'b0, 101);
        chk("abort_rd_row", 32'(rd_row_a), 32'd3);
        chk("abort_pulses_before", pulse_n[0], 84);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_pipe_off", 32'({rd_en_a, conv_en_a, out_valid_a}), 32'd0);
        chk("abort_done_busy", 32'({done_a, busy_a}), 32'h2);
        @(negedge clk);
        chk("abort_idle", 32'({done_a, busy_a, rd_en_a}), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
